// File: rtl/sfp_stream_framer.sv
// sfp_stream_framer: bridges a wide frame word to/from an AXI-Stream SFP core.
// TX serialises a latched frame into N beats, MSB beat first. RX gathers N beats
// into a frame word and flags short, long and stalled frames as errors.
module sfp_stream_framer #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_DATA_STREAM_BIT  = 256,
  parameter int C_RX_TIMEOUT       = 64
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [C_DATA_STREAM_BIT-1:0]  i_tx_stream_data,
  input  logic                          i_sfp_start_flag,
  output logic [C_DATA_STREAM_BIT-1:0]  o_rx_stream_data,
  output logic                          o_sfp_end_flag,
  input  logic                          i_channel_up,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic                          o_tx_busy,
  output logic                          o_rx_err
);

  localparam int W  = C_AXIS_TDATA_WIDTH;
  localparam int D  = C_DATA_STREAM_BIT;
  localparam int N  = D / W;
  localparam int CW = $clog2(N);
  localparam int TW = $clog2(C_RX_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(C_RX_TIMEOUT - 1);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_COLLECT, RX_DISCARD} rx_state_t;

  // ---------------- TX path ----------------
  tx_state_t       r_tx_state, w_tx_next;
  logic [D-1:0]    r_tx_shift;
  logic [CW-1:0]   r_tx_cnt;
  logic            w_tx_load;
  logic            w_tx_hs;

  assign m_axis_tvalid = (r_tx_state == TX_SEND);
  assign m_axis_tdata  = r_tx_shift[D-1 -: W];
  assign m_axis_tlast  = m_axis_tvalid && (r_tx_cnt == CNT_LAST);
  assign o_tx_busy     = m_axis_tvalid;
  assign w_tx_hs       = m_axis_tvalid & m_axis_tready;

  // TX state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_tx_state <= TX_IDLE;
    else        r_tx_state <= w_tx_next;
  end

  // TX next state: accept a start only when idle with the link up
  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_load = 1'b0;
    if (!i_channel_up) begin
      w_tx_next = TX_IDLE;
    end else begin
      case (r_tx_state)
        TX_IDLE: if (i_sfp_start_flag) begin
          w_tx_load = 1'b1;
          w_tx_next = TX_SEND;
        end
        TX_SEND: if (w_tx_hs && m_axis_tlast) w_tx_next = TX_IDLE;
        default: w_tx_next = TX_IDLE;
      endcase
    end
  end

  // TX shift register and beat counter
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tx_shift <= '0;
      r_tx_cnt   <= '0;
    end else if (!i_channel_up) begin
      r_tx_cnt   <= '0;
    end else if (w_tx_load) begin
      r_tx_shift <= i_tx_stream_data;
      r_tx_cnt   <= '0;
    end else if (w_tx_hs) begin
      r_tx_shift <= r_tx_shift << W;
      r_tx_cnt   <= m_axis_tlast ? '0 : r_tx_cnt + CW'(1);
    end
  end

  // ---------------- RX path ----------------
  rx_state_t       r_rx_state, w_rx_next;
  logic [D-1:0]    r_rx_shift;
  logic [D-1:0]    r_rx_data;
  logic [CW-1:0]   r_rx_cnt;
  logic [TW-1:0]   r_idle_cnt;
  logic            r_end_flag;
  logic            r_rx_err;
  logic            w_rx_beat;
  logic            w_rx_shift_en;
  logic            w_rx_deliver;
  logic            w_rx_err;
  logic            w_rx_clr;

  assign s_axis_tready    = i_channel_up;
  assign w_rx_beat        = s_axis_tvalid & i_channel_up;
  assign o_rx_stream_data = r_rx_data;
  assign o_sfp_end_flag   = r_end_flag;
  assign o_rx_err         = r_rx_err;

  // RX state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_rx_state <= RX_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  // RX next state: classify each beat as good end, short, long, or continuation
  always_comb begin
    w_rx_next     = r_rx_state;
    w_rx_shift_en = 1'b0;
    w_rx_deliver  = 1'b0;
    w_rx_err      = 1'b0;
    w_rx_clr      = 1'b0;
    if (!i_channel_up) begin
      w_rx_next = RX_IDLE;
      w_rx_clr  = 1'b1;
      w_rx_err  = (r_rx_state == RX_COLLECT);
    end else begin
      case (r_rx_state)
        RX_IDLE, RX_COLLECT: begin
          if (w_rx_beat) begin
            if (s_axis_tlast) begin
              w_rx_next = RX_IDLE;
              w_rx_clr  = 1'b1;
              if (r_rx_cnt == CNT_LAST) w_rx_deliver = 1'b1;
              else                      w_rx_err     = 1'b1;
            end else if (r_rx_cnt == CNT_LAST) begin
              w_rx_next = RX_DISCARD;
              w_rx_clr  = 1'b1;
              w_rx_err  = 1'b1;
            end else begin
              w_rx_next     = RX_COLLECT;
              w_rx_shift_en = 1'b1;
            end
          end else if (r_rx_state == RX_COLLECT && r_idle_cnt == TO_LAST) begin
            w_rx_next = RX_IDLE;
            w_rx_clr  = 1'b1;
            w_rx_err  = 1'b1;
          end
        end
        RX_DISCARD: if (w_rx_beat && s_axis_tlast) w_rx_next = RX_IDLE;
        default:    w_rx_next = RX_IDLE;
      endcase
    end
  end

  // RX datapath: shift register, counters, delivered frame and pulses
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_cnt   <= '0;
      r_idle_cnt <= '0;
      r_end_flag <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_end_flag <= w_rx_deliver;
      r_rx_err   <= w_rx_err;
      if (w_rx_deliver) r_rx_data <= {r_rx_shift[D-W-1:0], s_axis_tdata};
      if (w_rx_shift_en) r_rx_shift <= {r_rx_shift[D-W-1:0], s_axis_tdata};
      if (w_rx_clr)           r_rx_cnt <= '0;
      else if (w_rx_shift_en) r_rx_cnt <= r_rx_cnt + CW'(1);
      if (w_rx_shift_en || w_rx_clr || r_rx_state != RX_COLLECT) r_idle_cnt <= '0;
      else                                                       r_idle_cnt <= r_idle_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_sfp_stream_framer.sv
// Randomised self-checking bench for sfp_stream_framer (W=32, D=256, N=8).
module tb_sfp_stream_framer;
  localparam int W  = 32;
  localparam int D  = 256;
  localparam int N  = D / W;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [D-1:0] tx_data = '0;
  logic         start = 1'b0;
  logic [D-1:0] rx_data;
  logic         end_flag;
  logic         chan_up = 1'b1;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic         m_tlast;
  logic [W-1:0] s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic         s_tlast = 1'b0;
  logic         tx_busy;
  logic         rx_err;

  int checks = 0;
  int errors = 0;

  logic [D-1:0] exp_rx_data = '0;
  logic [D-1:0] txf;
  logic [W-1:0] tx_beats[$];
  logic         tx_lasts[$];
  int           busy_cycles = 0;
  bit           stalled = 1'b0;
  logic [W-1:0] held_d;
  logic         held_l;

  always #5 clk = ~clk;

  sfp_stream_framer #(
    .C_AXIS_TDATA_WIDTH(W),
    .C_DATA_STREAM_BIT (D),
    .C_RX_TIMEOUT      (TO)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst_n),
    .i_tx_stream_data (tx_data),
    .i_sfp_start_flag (start),
    .o_rx_stream_data (rx_data),
    .o_sfp_end_flag   (end_flag),
    .i_channel_up     (chan_up),
    .m_axis_tdata     (m_tdata),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tready    (m_tready),
    .m_axis_tlast     (m_tlast),
    .s_axis_tdata     (s_tdata),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tready    (s_tready),
    .s_axis_tlast     (s_tlast),
    .o_tx_busy        (tx_busy),
    .o_rx_err         (rx_err)
  );

  task automatic check(input string tag, input logic [D-1:0] got, input logic [D-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat k of a frame is the k-th W-bit slice counted from the MSB end.
  function automatic logic [W-1:0] slice(input logic [D-1:0] f, input int k);
    logic [D-1:0] t;
    t = f >> (D - W * (k + 1));
    return t[W-1:0];
  endfunction

  // Capture TX handshakes and verify data/last hold steady across stalls.
  always @(negedge clk) begin
    if (rst_n && m_tvalid) begin
      if (stalled) begin
        check("tx_hold_data", D'(m_tdata), D'(held_d));
        check("tx_hold_last", D'(m_tlast), D'(held_l));
      end
      if (m_tready) begin
        tx_beats.push_back(m_tdata);
        tx_lasts.push_back(m_tlast);
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held_d  = m_tdata;
        held_l  = m_tlast;
      end
    end else begin
      stalled = 1'b0;
    end
    if (tx_busy) busy_cycles++;
  end

  task automatic check_tx(input logic [D-1:0] f);
    check("tx_beat_count", D'(tx_beats.size()), D'(N));
    for (int k = 0; k < N; k++) begin
      if (k < tx_beats.size()) begin
        check("tx_data", D'(tx_beats[k]), D'(slice(f, k)));
        check("tx_last", D'(tx_lasts[k]), D'(k == N - 1));
      end
    end
  endtask

  // mode 0: tready held 1; 1: toggled each cycle; 2: random. A second start mid-frame must be ignored.
  task automatic tx_frame(input logic [D-1:0] f, input int mode);
    tx_beats.delete();
    tx_lasts.delete();
    busy_cycles = 0;
    tx_data  = f;
    start    = 1'b1;
    m_tready = (mode == 0);
    tick();
    start = 1'b0;
    check("tx_first_valid", D'(m_tvalid), D'(1'b1));
    check("tx_first_data", D'(m_tdata), D'(slice(f, 0)));
    for (int c = 0; c < 6 * N + 8; c++) begin
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
      if (c == 3) begin
        tx_data = ~f;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check_tx(f);
    if (mode == 0) check("tx_busy_cycles", D'(busy_cycles), D'(N));
    check("tx_busy_end", D'(tx_busy), D'(1'b0));
  endtask

  // Sends n beats, tlast on the n-th; model: only n==N delivers, n<N errs at the end, n>N errs at beat N.
  task automatic rx_frame(input int n, input bit gaps, input bit fixed, input bit with_start);
    logic [D-1:0] acc;
    bit exp_end, exp_err;
    acc = '0;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          tick();
          check("rx_gap_end", D'(end_flag), D'(1'b0));
          check("rx_gap_err", D'(rx_err), D'(1'b0));
        end
      end
      s_tvalid = 1'b1;
      s_tdata  = fixed ? W'(32'hA0 + k) : W'($urandom);
      s_tlast  = (k == n - 1);
      if (with_start && k == n - 1) begin
        tx_beats.delete();
        tx_lasts.delete();
        txf      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        tx_data  = txf;
        start    = 1'b1;
        m_tready = 1'b1;
      end
      acc = (acc << W) | D'(s_tdata);
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      start    = 1'b0;
      exp_end  = (k == n - 1) && (n == N);
      exp_err  = ((n < N) && (k == n - 1)) || ((n > N) && (k == N - 1));
      if (exp_end) exp_rx_data = acc;
      check("rx_end_flag", D'(end_flag), D'(exp_end));
      check("rx_err_flag", D'(rx_err), D'(exp_err));
      if (with_start && k == n - 1) check("tx_busy_concurrent", D'(tx_busy), D'(1'b1));
    end
    check("rx_data", rx_data, exp_rx_data);
    tick();
    check("rx_end_once", D'(end_flag), D'(1'b0));
    check("rx_err_once", D'(rx_err), D'(1'b0));
  endtask

  initial begin
    logic [D-1:0] pat;
    int err_at, err_n, end_n, n;

    repeat (3) tick();
    check("rst_tvalid", D'(m_tvalid), D'(1'b0));
    check("rst_tlast", D'(m_tlast), D'(1'b0));
    check("rst_tdata", D'(m_tdata), D'(0));
    check("rst_busy", D'(tx_busy), D'(1'b0));
    check("rst_end", D'(end_flag), D'(1'b0));
    check("rst_err", D'(rx_err), D'(1'b0));
    check("rst_rx_data", rx_data, D'(0));
    check("rst_s_tready", D'(s_tready), D'(1'b1));
    rst_n = 1'b1;
    tick();

    // TX: byte pattern 00,11,..,FF repeated, full-rate
    pat = '0;
    for (int i = 0; i < D / 8; i++) pat = (pat << 8) | D'((i % 16) * 8'h11);
    tx_frame(pat, 0);
    // TX: tready toggling, then random back-pressure
    tx_frame({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1);
    repeat (3) tx_frame({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2);

    // RX: fixed good frame, short, good, long, good
    rx_frame(N, 1'b0, 1'b1, 1'b0);
    rx_frame(5, 1'b0, 1'b0, 1'b0);
    rx_frame(N, 1'b0, 1'b0, 1'b0);
    rx_frame(10, 1'b0, 1'b0, 1'b0);
    rx_frame(N, 1'b0, 1'b0, 1'b0);
    // RX: random lengths with random gaps
    repeat (8) begin
      n = ($urandom_range(0, 1) == 0) ? N : int'($urandom_range(1, 12));
      rx_frame(n, 1'b1, 1'b0, 1'b0);
    end

    // RX completion and TX start in the same cycle
    rx_frame(N, 1'b0, 1'b0, 1'b1);
    repeat (N + 2) tick();
    check_tx(txf);

    // RX timeout: 3 beats then silence
    for (int k = 0; k < 3; k++) begin
      s_tvalid = 1'b1;
      s_tdata  = W'($urandom);
      tick();
      s_tvalid = 1'b0;
    end
    err_at = -1;
    err_n  = 0;
    end_n  = 0;
    for (int k = 1; k <= TO + 6; k++) begin
      tick();
      if (rx_err) begin
        err_n++;
        if (err_at < 0) err_at = k;
      end
      if (end_flag) end_n++;
    end
    check("rx_timeout_at", D'(err_at), D'(TO));
    check("rx_timeout_pulses", D'(err_n), D'(1));
    check("rx_timeout_no_end", D'(end_n), D'(0));
    check("rx_timeout_data", rx_data, exp_rx_data);
    rx_frame(N, 1'b1, 1'b0, 1'b0);

    // RX aborted by link drop mid-frame
    for (int k = 0; k < 3; k++) begin
      s_tvalid = 1'b1;
      s_tdata  = W'($urandom);
      tick();
      s_tvalid = 1'b0;
    end
    chan_up = 1'b0;
    tick();
    check("rx_drop_err", D'(rx_err), D'(1'b1));
    check("rx_drop_tready", D'(s_tready), D'(1'b0));
    check("rx_drop_end", D'(end_flag), D'(1'b0));
    chan_up = 1'b1;
    tick();
    check("rx_drop_err_once", D'(rx_err), D'(1'b0));
    check("rx_drop_data", rx_data, exp_rx_data);
    rx_frame(N, 1'b0, 1'b0, 1'b0);

    // TX aborted by link drop; start while link down ignored
    m_tready = 1'b0;
    tx_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("tx_stall_busy", D'(tx_busy), D'(1'b1));
    chan_up = 1'b0;
    tick();
    check("tx_drop_valid", D'(m_tvalid), D'(1'b0));
    check("tx_drop_busy", D'(tx_busy), D'(1'b0));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("tx_start_link_down", D'(tx_busy), D'(1'b0));
    chan_up = 1'b1;
    tick();
    check("tx_after_link_up", D'(tx_busy), D'(1'b0));

    // Reset in the middle of an RX frame
    for (int k = 0; k < 4; k++) begin
      s_tvalid = 1'b1;
      s_tdata  = W'($urandom);
      tick();
      s_tvalid = 1'b0;
    end
    rst_n = 1'b0;
    #2;
    check("rst_mid_rx_data", rx_data, D'(0));
    check("rst_mid_busy", D'(tx_busy), D'(1'b0));
    check("rst_mid_end", D'(end_flag), D'(1'b0));
    exp_rx_data = '0;
    tick();
    rst_n = 1'b1;
    tick();
    rx_frame(N, 1'b1, 1'b0, 1'b0);
    tx_frame({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
